// File: rtl/lane_permuter.sv
// ---------------------------------------------------------------------------
// lane_permuter
//
// Permutes each incoming word according to a 2-bit mode and queues the
// result in a small output FIFO. The permutation is applied at push time,
// so the FIFO holds finished words and later mode changes cannot affect them.
//
// Modes (byte k = bits [8k+7:8k], N = DATA_W/8):
//   00  pass-through
//   01  swap the nibbles inside every byte
//   10  reverse byte order (byte k -> byte N-1-k)
//   11  nibble swap followed by byte reversal (full nibble-order reversal)
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      asynchronous, active-high reset
//   in_data    word to permute
//   in_mode    permutation select, sampled together with in_data
//   in_valid   producer has a word
//   in_ready   block can accept a word (FIFO not full)
//   out_data   permuted word at the FIFO head, 0 while the FIFO is empty
//   out_valid  FIFO head holds a valid word
//   out_ready  consumer accepts the head word
//   level      current FIFO occupancy
//   xfer_cnt   free-running count of accepted input words (wraps at 16 bits)
// ---------------------------------------------------------------------------
module lane_permuter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [1:0]               in_mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              xfer_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned NB = DATA_W / 8;

    localparam logic [AW:0]   LVL_FULL = DEPTH[AW:0];
    localparam logic [AW:0]   LVL_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q,  level_d;
    logic [15:0]       xfer_q,   xfer_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // -----------------------------------------------------------------------
    // Permutation network
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] nib_swapped;
    logic [DATA_W-1:0] perm_src;
    logic [DATA_W-1:0] perm_data;

    always_comb begin
        nib_swapped = '0;
        for (int k = 0; k < NB; k++) begin
            nib_swapped[8*k +: 8] = {in_data[8*k +: 4], in_data[8*k+4 +: 4]};
        end
    end

    // Bit 0 selects the nibble swap, bit 1 the byte reversal applied after it.
    assign perm_src = in_mode[0] ? nib_swapped : in_data;

    always_comb begin
        perm_data = perm_src;
        if (in_mode[1]) begin
            for (int k = 0; k < NB; k++) begin
                perm_data[8*k +: 8] = perm_src[8*(NB-1-k) +: 8];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Handshakes
    // -----------------------------------------------------------------------
    logic push;
    logic pop;

    // in_ready looks only at occupancy: a full FIFO refuses a word even when
    // a pop happens on the same edge.
    assign in_ready  = (level_q < LVL_FULL);
    assign out_valid = (level_q != '0);

    assign push = in_valid  & in_ready;
    assign pop  = out_valid & out_ready;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        xfer_d   = xfer_q;

        // DEPTH is a power of two, so pointer overflow is the modulo wrap.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            xfer_d   = xfer_q + 16'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = perm_data;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            xfer_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            xfer_q   <= xfer_d;
        end
    end

    // Storage needs no reset: stale entries are unreachable once the
    // pointers and level are cleared, and out_data is masked while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign out_data = (level_q == '0) ? '0 : mem_q[rd_ptr_q];
    assign level    = level_q;
    assign xfer_cnt = xfer_q;

endmodule
